systolic_mm_engine: RTL and testbench
=====================================

Name: systolic_mm_engine

Overview:
- Parametrised NxN output-stationary systolic matrix multiplier computing C = A x B; next-generation replacement for the fixed 3x3 array.
- Adds input skewing internal to the block, valid/ready handshakes on operand and result sides, and a control FSM with stall support.
- Sits between operand buffers (column-of-A / row-of-B streams) and the result consumer.

Parameters:
- N, 3, matrix dimension (N >= 1).
- DATA_W, 8, operand element width.
- ACC_W, 2*DATA_W+$clog2(N+1), accumulator / result element width.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset; reset=0 asserts.
- start  input  1  begin a job; honoured only in IDLE.
- busy  output  1  state != IDLE.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  high in LOAD.
- a_col  input  N*DATA_W  column k of A; element i at [i*DATA_W +: DATA_W].
- b_row  input  N*DATA_W  row k of B; element j at [j*DATA_W +: DATA_W].
- out_valid  output  1  result matrix valid (state DONE).
- out_ready  input  1  consumer accepts result.
- c_flat  output  N*N*ACC_W  C(i,j) at index i*N+j; driven from accumulators; defined only while out_valid.

Behaviour:
- FSM states IDLE, LOAD, DRAIN, DONE. Reset: IDLE, all accumulators, skew and PE pipeline registers 0; busy, in_ready, out_valid, c_flat = 0.
- IDLE: start=1 -> LOAD; the same edge clears all accumulators and pipeline registers, beat counter = 0.
- LOAD: step enable = in_valid & in_ready. Each step shifts a_col/b_row into skew lines (row i / column j delayed by i / j steps) and advances the array one step. in_valid=0 -> full array stall, no state change. After the Nth accepted beat -> DRAIN (or directly DONE when N=1).
- DRAIN: array steps every cycle with zero operands injected, for exactly 2N-2 steps, then -> DONE.
- PE(i,j): at each enabled step, acc += a_in*b_in; forwards a right and b down through registers. a[i][k] and b[k][j] meet in PE(i,j) at step k+i+j; last MAC at step 3N-3.
- DONE: out_valid=1, c_flat stable until out_valid & out_ready -> IDLE.
- Latency: with gapless beats, first beat presented in cycle 0 -> out_valid high in cycle 3N-2 (N=3: cycle 7).
- start outside IDLE ignored; in_valid outside LOAD ignored; out_ready outside DONE ignored.
- Products DATA_W x DATA_W -> 2*DATA_W, extended to ACC_W before accumulation; default ACC_W cannot overflow; overflow with a user-narrowed ACC_W wraps modulo 2^ACC_W.
- reset asserted mid-job: immediate return to reset state; partial job discarded.

Optional Feature:
- SYSMM_SIGNED_EN defined: operands and results are two's complement; products and accumulation sign-extended.
- Undefined: all unsigned, zero-extended.

Decomposition:
- Package systolic_mm_pkg: state enum type, default-ACC_W helper function, step-count constants (DRAIN_STEPS = 2N-2).
- Sub-module systolic_mm_pe: one MAC cell with enable, clear, a/b forward registers and accumulator; instantiated NxN in a generate block.

Test Plan:
- N=3, gapless beats: a_col [3,5,1],[12,6,0],[4,8,2]; b_row [7,3,8],[11,9,5],[6,8,4] -> C rows [177,149,100],[149,133,102],[19,19,16]; out_valid first high cycle 7.
- Same job with in_valid low 2 cycles between each beat and out_ready low 5 cycles -> identical C; c_flat stable while out_valid & !out_ready; one result handshake only.
- All operands 255 (unsigned) -> every C = 195075. With SYSMM_SIGNED_EN, all operands -128 -> every C = 49152; A all -1 and B all 2 -> every C = -6.
- Reset driven to 0 during DRAIN -> busy=0, out_valid=0 next cycle. A new job of identity A times B -> C == B, with no residue from the aborted job.
- Back-to-back jobs: start held high in the handshake cycle is ignored. start on the next cycle -> second result correct, proving accumulators are cleared.
- N=1 build: a_col=9, b_row=7 -> C=63, out_valid in cycle 1. start and in_valid pulsed while busy -> no effect.

Source files
------------

// File: rtl/systolic_mm_pkg.sv
// -----------------------------------------------------------------------------
// systolic_mm_pkg
// Shared types and sizing helpers for the systolic matrix-multiply engine.
//   state_e        : control FSM states (IDLE, LOAD, DRAIN, DONE)
//   default_acc_w  : accumulator width that cannot overflow for an N-term dot
//                    product of DATA_W x DATA_W products
//   drain_steps    : zero-operand steps needed after the last beat (2N-2)
// -----------------------------------------------------------------------------
package systolic_mm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic int default_acc_w(input int n, input int data_w);
        return 2 * data_w + $clog2(n + 1);
    endfunction

    // The last operand pair enters PE(0,0) at step N-1 and needs 2N-2 more
    // steps to reach PE(N-1,N-1).
    function automatic int drain_steps(input int n);
        return 2 * n - 2;
    endfunction

endpackage

// File: rtl/systolic_mm_pe.sv
// -----------------------------------------------------------------------------
// systolic_mm_pe
// One output-stationary MAC cell. On each enabled step it adds a_in*b_in to
// its accumulator and registers a_in / b_in for the right / lower neighbour.
// clr has priority over en and zeroes all cell state.
// Optional macro SYSMM_SIGNED_EN: operands are two's complement and the
// product is sign-extended into the accumulator; otherwise zero-extended.
// Ports:
//   clk, reset (async, active-low)
//   en, clr          : step enable, synchronous clear
//   a_in, b_in       : operands from left / top
//   a_out, b_out     : registered operands to right / bottom
//   acc              : accumulator (ACC_W bits, wraps modulo 2^ACC_W)
// -----------------------------------------------------------------------------
module systolic_mm_pe
    import systolic_mm_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 18
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              clr,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [ACC_W-1:0]  acc
);

    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]    prod_ext;

    always_comb begin
`ifdef SYSMM_SIGNED_EN
        prod     = $signed({{DATA_W{a_in[DATA_W-1]}}, a_in}) *
                   $signed({{DATA_W{b_in[DATA_W-1]}}, b_in});
        prod_ext = ACC_W'($signed(prod));
`else
        prod     = {{DATA_W{1'b0}}, a_in} * {{DATA_W{1'b0}}, b_in};
        prod_ext = ACC_W'(prod);
`endif
    end

    // NOTE: every _d gets its hold value first, so no path can infer a latch.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        if (clr) begin
            a_d   = '0;
            b_d   = '0;
            acc_d = '0;
        end else if (en) begin
            a_d   = a_in;
            b_d   = b_in;
            acc_d = acc_q + prod_ext;
        end
    end

    // NOTE: non-blocking assignments so every cell samples its neighbours'
    // pre-edge values, which is what makes the array shift in lockstep.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
        end
    end

    assign a_out = a_q;
    assign b_out = b_q;
    assign acc   = acc_q;

endmodule

// File: rtl/systolic_mm_engine.sv
// -----------------------------------------------------------------------------
// systolic_mm_engine
// NxN output-stationary systolic multiplier, C = A x B. Operands arrive as N
// beats (column k of A with row k of B); the block skews them internally,
// drains the array, then presents the whole C matrix until accepted.
// Optional macro SYSMM_SIGNED_EN: two's-complement operands and results.
// Ports:
//   clk, reset (async, active-low)
//   start                    : begin a job (honoured only when idle)
//   busy                     : job in progress or result pending
//   in_valid / in_ready      : operand beat handshake (ready while loading)
//   a_col, b_row             : element i / j at [i*DATA_W +: DATA_W]
//   out_valid / out_ready    : result handshake
//   c_flat                   : C(i,j) at [(i*N+j)*ACC_W +: ACC_W]
// -----------------------------------------------------------------------------
module systolic_mm_engine
    import systolic_mm_pkg::*;
#(
    parameter int N      = 3,
    parameter int DATA_W = 8,
    parameter int ACC_W  = default_acc_w(N, DATA_W)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N*DATA_W-1:0]   a_col,
    input  logic [N*DATA_W-1:0]   b_row,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N*N*ACC_W-1:0]  c_flat
);

    localparam int DRAIN_STEPS = drain_steps(N);
    localparam int CNT_W       = $clog2(2 * N + 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             step;
    logic             clr;
    logic             inject;

    // ---------------- control FSM ----------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        step      = 1'b0;
        clr       = 1'b0;
        busy      = (state_q != ST_IDLE);
        in_ready  = (state_q == ST_LOAD);
        out_valid = (state_q == ST_DONE);
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                    clr     = 1'b1;
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    step = 1'b1;
                    if (cnt_q == CNT_W'(N - 1)) begin
                        cnt_d   = '0;
                        state_d = (N == 1) ? ST_DONE : ST_DRAIN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                step = 1'b1;
                if (cnt_q == CNT_W'(DRAIN_STEPS - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outside LOAD the array is fed zeros, so draining adds nothing.
    assign inject = (state_q == ST_LOAD);

    // ---------------- input skew ----------------
    // Row i of A and column i of B share a delay line of i stages so that
    // a[i][k] and b[k][j] meet in PE(i,j) at step k+i+j.
    logic [DATA_W-1:0] a_edge [N];
    logic [DATA_W-1:0] b_edge [N];

    for (genvar s = 0; s < N; s++) begin : g_skew
        logic [DATA_W-1:0] a_inj, b_inj;
        assign a_inj = inject ? a_col[s*DATA_W +: DATA_W] : '0;
        assign b_inj = inject ? b_row[s*DATA_W +: DATA_W] : '0;

        if (s == 0) begin : g_direct
            assign a_edge[s] = a_inj;
            assign b_edge[s] = b_inj;
        end else begin : g_line
            logic [2*DATA_W-1:0] line_q [s];
            logic [2*DATA_W-1:0] line_d [s];

            always_comb begin
                line_d = line_q;
                if (clr) begin
                    for (int m = 0; m < s; m++) line_d[m] = '0;
                end else if (step) begin
                    line_d[0] = {a_inj, b_inj};
                    for (int m = 1; m < s; m++) line_d[m] = line_q[m-1];
                end
            end

            // NOTE: the delay lines are plain registers, not a RAM, and are
            // reset element by element so an aborted job leaves no residue.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int m = 0; m < s; m++) line_q[m] <= '0;
                end else begin
                    line_q <= line_d;
                end
            end

            assign a_edge[s] = line_q[s-1][2*DATA_W-1:DATA_W];
            assign b_edge[s] = line_q[s-1][DATA_W-1:0];
        end
    end

    // ---------------- PE array ----------------
    logic [DATA_W-1:0] a_fwd [N][N];
    logic [DATA_W-1:0] b_fwd [N][N];
    logic [ACC_W-1:0]  acc   [N][N];

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic [DATA_W-1:0] a_in, b_in;

            if (j == 0) begin : g_a_edge
                assign a_in = a_edge[i];
            end else begin : g_a_fwd
                assign a_in = a_fwd[i][j-1];
            end

            if (i == 0) begin : g_b_edge
                assign b_in = b_edge[j];
            end else begin : g_b_fwd
                assign b_in = b_fwd[i-1][j];
            end

            systolic_mm_pe #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W)
            ) u_pe (
                .clk   (clk),
                .reset (reset),
                .en    (step),
                .clr   (clr),
                .a_in  (a_in),
                .b_in  (b_in),
                .a_out (a_fwd[i][j]),
                .b_out (b_fwd[i][j]),
                .acc   (acc[i][j])
            );

            assign c_flat[(i*N+j)*ACC_W +: ACC_W] = acc[i][j];
        end
    end

endmodule

// File: tb/tb_systolic_mm_engine.sv
// -----------------------------------------------------------------------------
// tb_systolic_mm_engine
// Scoreboard bench: each job pushes its expected C (from a plain matrix
// product, or a known table for the directed job) into a queue; a monitor
// pops and compares on every result handshake and checks that c_flat holds
// while the consumer stalls. Build with SYSMM_SIGNED_EN for the signed flavour.
// -----------------------------------------------------------------------------
module tb_systolic_mm_engine;
    import systolic_mm_pkg::*;

    localparam int N          = 3;
    localparam int DATA_W     = 8;
    localparam int ACC_W      = default_acc_w(N, DATA_W);
    localparam int WAIT_LIMIT = 400;

    typedef int mat_t [N][N];
    typedef logic [N*N*ACC_W-1:0] cvec_t;

    logic                 clk       = 1'b0;
    logic                 reset     = 1'b0;
    logic                 start     = 1'b0;
    logic                 in_valid  = 1'b0;
    logic                 out_ready = 1'b0;
    logic [N*DATA_W-1:0]  a_col     = '0;
    logic [N*DATA_W-1:0]  b_row     = '0;
    logic                 busy, in_ready, out_valid;
    logic [N*N*ACC_W-1:0] c_flat;

    int    total = 0;
    int    bad   = 0;
    cvec_t exp_q [$];

    systolic_mm_engine #(
        .N      (N),
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_col     (a_col),
        .b_row     (b_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c_flat    (c_flat)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [63:0] elem(input cvec_t v, input int idx);
        logic [ACC_W-1:0] e;
        e = v[idx*ACC_W +: ACC_W];
        return 64'(e);
    endfunction

    function automatic int rand_val();
`ifdef SYSMM_SIGNED_EN
        return int'($urandom_range(0, (1 << DATA_W) - 1)) - (1 << (DATA_W - 1));
`else
        return int'($urandom_range(0, (1 << DATA_W) - 1));
`endif
    endfunction

    // Reference: textbook matrix product, reduced modulo 2^ACC_W.
    function automatic cvec_t model(input mat_t a, input mat_t b);
        cvec_t  r;
        longint sum;
        r = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                sum = 0;
                for (int k = 0; k < N; k++) sum += longint'(a[i][k]) * longint'(b[k][j]);
                r[(i*N+j)*ACC_W +: ACC_W] = sum[ACC_W-1:0];
            end
        return r;
    endfunction

    task automatic drive_beat(input mat_t a, input mat_t b, input int k);
        for (int s = 0; s < N; s++) begin
            a_col[s*DATA_W +: DATA_W] = DATA_W'(a[s][k]);
            b_row[s*DATA_W +: DATA_W] = DATA_W'(b[k][s]);
        end
    endtask

    task automatic junk_ops();
        for (int s = 0; s < N; s++) begin
            a_col[s*DATA_W +: DATA_W] = DATA_W'($urandom);
            b_row[s*DATA_W +: DATA_W] = DATA_W'($urandom);
        end
    endtask

    task automatic do_reset();
        start = 0; in_valid = 0; out_ready = 0; a_col = '0; b_row = '0;
        reset = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1;
    endtask

    // One full job. gap: idle cycles between beats (random 0..gap if gap_rand),
    // rdy_dly: cycles out_ready stays low, hs_start: start held in the
    // handshake cycle, poke: start/in_valid pulsed while busy.
    task automatic run_job(input mat_t a, input mat_t b, input cvec_t exp_c,
                           input int gap, input bit gap_rand, input int rdy_dly,
                           input bit hs_start, input bit poke);
        int cyc, last, g_n, waited;
        exp_q.push_back(exp_c);
        start = 1;
        @(posedge clk); #1;
        start = 0;
        cyc = 0; last = 0;
        for (int k = 0; k < N; k++) begin
            check("in_ready_load", in_ready, 1);
            drive_beat(a, b, k);
            in_valid = 1;
            last = cyc;
            @(posedge clk); #1; cyc++;
            in_valid = 0;
            if (k < N - 1) begin
                g_n = gap_rand ? int'($urandom_range(0, gap)) : gap;
                for (int g = 0; g < g_n; g++) begin
                    start = poke;
                    @(posedge clk); #1; cyc++;
                end
                start = 0;
            end
        end
        waited = 0;
        while (out_valid !== 1'b1 && waited < WAIT_LIMIT) begin
            if (poke) begin start = 1; in_valid = 1; junk_ops(); end
            @(posedge clk); #1; cyc++; waited++;
        end
        start = 0; in_valid = 0;
        check("out_valid_seen", out_valid, 1);
        if (out_valid !== 1'b1) begin
            exp_q.delete();
            do_reset();
            return;
        end
        check("latency", cyc, last + 2*N - 1);
        check("busy_done", busy, 1);
        for (int r = 0; r < rdy_dly; r++) begin
            if (poke) begin start = 1; in_valid = 1; junk_ops(); end
            @(posedge clk); #1;
            check("out_valid_hold", out_valid, 1);
        end
        start = hs_start; in_valid = 0; out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0; start = 0;
        check("busy_after_hs", busy, 0);
        check("out_valid_after_hs", out_valid, 0);
    endtask

    // Job aborted by reset after the operands went in.
    task automatic abort_job(input mat_t a, input mat_t b);
        start = 1;
        @(posedge clk); #1;
        start = 0;
        for (int k = 0; k < N; k++) begin
            drive_beat(a, b, k);
            in_valid = 1;
            @(posedge clk); #1;
        end
        in_valid = 0;
        @(posedge clk); #1;
        check("busy_before_abort", busy, 1);
        reset = 0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 0);
        @(posedge clk); #1;
        for (int e = 0; e < N*N; e++) check($sformatf("abort_c[%0d]", e), elem(c_flat, e), 0);
        reset = 1;
        @(posedge clk); #1;
    endtask

    // Monitor: stability while stalled, scoreboard compare on handshake.
    initial begin : monitor
        cvec_t snap, exp_c;
        bit    held;
        held = 0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1 || out_valid !== 1'b1) begin
                held = 0;
            end else begin
                if (held) begin
                    for (int e = 0; e < N*N; e++)
                        check($sformatf("c_stable[%0d]", e), elem(c_flat, e), elem(snap, e));
                end else begin
                    held = 1;
                    snap = c_flat;
                end
                if (out_ready === 1'b1) begin
                    check("result_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        exp_c = exp_q.pop_front();
                        for (int e = 0; e < N*N; e++)
                            check($sformatf("c[%0d]", e), elem(c_flat, e), elem(exp_c, e));
                    end
                    held = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        mat_t  a, b, id;
        cvec_t e;
        int    tp_a [9] = '{3, 12, 4, 5, 6, 8, 1, 0, 2};
        int    tp_b [9] = '{7, 3, 8, 11, 9, 5, 6, 8, 4};
        int    tp_c [9] = '{177, 149, 100, 149, 133, 102, 19, 19, 16};

        reset = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_in_ready", in_ready, 0);
        check("reset_out_valid", out_valid, 0);
        for (int i = 0; i < N*N; i++) check($sformatf("reset_c[%0d]", i), elem(c_flat, i), 0);
        reset = 1;
        @(posedge clk); #1;

        // Directed job: known 3x3 vectors, or 9 x 7 for the 1x1 build.
        e = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                if (N == 3) begin
                    a[i][j] = tp_a[i*3+j];
                    b[i][j] = tp_b[i*3+j];
                    e[(i*N+j)*ACC_W +: ACC_W] = ACC_W'(tp_c[i*3+j]);
                end else if (N == 1) begin
                    a[i][j] = 9;
                    b[i][j] = 7;
                    e[(i*N+j)*ACC_W +: ACC_W] = ACC_W'(63);
                end else begin
                    a[i][j] = rand_val();
                    b[i][j] = rand_val();
                end
            end
        if (N != 3 && N != 1) e = model(a, b);
        run_job(a, b, e, 0, 0, 0, 0, 0);
        // Same job with gaps, consumer stall, pokes while busy, start in handshake.
        run_job(a, b, e, 2, 0, 5, 1, 1);

        // Extremes, issued on the cycle right after the previous handshake.
`ifdef SYSMM_SIGNED_EN
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                a[i][j] = -(1 << (DATA_W - 1));
                b[i][j] = -(1 << (DATA_W - 1));
            end
        run_job(a, b, model(a, b), 0, 0, 1, 0, 0);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                a[i][j] = -1;
                b[i][j] = 2;
            end
        run_job(a, b, model(a, b), 0, 0, 0, 0, 0);
`else
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                a[i][j] = (1 << DATA_W) - 1;
                b[i][j] = (1 << DATA_W) - 1;
            end
        run_job(a, b, model(a, b), 0, 0, 1, 0, 0);
`endif

        // Random jobs with random gaps, stalls and pokes.
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    a[i][j] = rand_val();
                    b[i][j] = rand_val();
                end
            run_job(a, b, model(a, b), 2, 1, int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Abort mid-job, then identity x B must give exactly B.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                a[i][j] = rand_val();
                b[i][j] = rand_val();
                id[i][j] = (i == j) ? 1 : 0;
            end
        abort_job(a, b);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) b[i][j] = rand_val();
        e = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                e[(i*N+j)*ACC_W +: ACC_W] = ACC_W'(b[i][j]);
        run_job(id, b, e, 0, 0, 0, 0, 0);

        repeat (5) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
